loop_sequencer: RTL and testbench
=================================

LOOP_SEQUENCER -- requirements
Module: loop_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, width of the loop-body output value.
REQ-002 The block SHALL have parameter CNT_W, default 16, width of the iteration limit and counter.
REQ-003 The block SHALL have parameter WDOG_CYCLES, default 1024, watchdog limit in RUN cycles (used only per REQ-027).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 start  input  1  request to begin a loop; sampled in IDLE only.
REQ-007 disable_req  input  1  named-block disable; aborts an active loop.
REQ-008 iter_limit  input  CNT_W  iteration count, sampled at start; 0 = forever.
REQ-009 body_val  input  DATA_W  value written by each body iteration, sampled at start.
REQ-010 o  output  DATA_W  loop-body result register.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  one-cycle pulse on loop exit.
REQ-013 aborted  output  1  qualifies done: exit was by disable or timeout.
REQ-014 iter_cnt  output  CNT_W  completed iterations of the current/last loop.
REQ-015 timeout  output  1  qualifies done: exit was by watchdog.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
- IDLE -> RUN on start==1.
- RUN -> DONE on completion, disable, or timeout.
- DONE -> IDLE unconditionally after one cycle.
REQ-017 On start in IDLE, the block SHALL latch iter_limit and body_val, clear iter_cnt, aborted and timeout, and enter RUN on the next edge.
REQ-018 Each RUN cycle without disable_req SHALL perform one iteration:
- o <= latched body_val.
- iter_cnt <= iter_cnt+1.
- First o write one cycle after start acceptance.
REQ-019 With latched limit N>0, the block SHALL leave RUN on the cycle completing iteration N: exactly N RUN cycles, iter_cnt==N in DONE, aborted=0.
REQ-020 With latched limit 0, the block SHALL stay in RUN until disable_req (or timeout); iter_cnt saturates at all-ones and does not wrap.
REQ-021 disable_req==1 in RUN SHALL, on that edge:
- Move to DONE with aborted=1.
- Perform no iteration: o and iter_cnt keep prior values.
REQ-022 disable_req coinciding with the final iteration SHALL take priority: aborted=1, iter_cnt==N-1.
REQ-023 disable_req in IDLE or DONE SHALL be ignored and not remembered; start and disable_req together in IDLE SHALL start the loop normally.
REQ-024 start in RUN or DONE SHALL be ignored (no queuing).
REQ-025 Output behaviour by state:
- done=1 only in DONE.
- busy=1 only in RUN.
- aborted, timeout, iter_cnt and o hold until the next accepted start.

Reset
REQ-026 rst_n low SHALL, asynchronously and at any time including mid-loop:
- Force state IDLE.
- Set o=1.
- Set iter_cnt=0, busy=0, done=0, aborted=0, timeout=0.
- Discard latched iter_limit and body_val.
- Produce no done pulse on reset release.

Configuration
REQ-027 Macro LOOP_SEQUENCER_WATCHDOG_EN:
- Defined: a cycle counter cleared on entering RUN SHALL force RUN -> DONE with aborted=1 and timeout=1 when WDOG_CYCLES RUN cycles have elapsed and no other exit occurs that edge. No iteration is performed on that edge.
- Disable or completion on the same edge wins, with timeout=0.
- Undefined: no watchdog logic; timeout is tied 0; forever loops end only by disable_req or reset.

Verification
REQ-028 Reset -> o==1, iter_cnt==0, busy==0, done==0.
REQ-029 start with iter_limit=3, body_val=10 -> busy for 3 cycles, o==10 from the cycle after start, done pulse with iter_cnt==3, aborted==0.
REQ-030 start with iter_limit=0, body_val=10, disable_req after 5 RUN cycles -> done, aborted==1, iter_cnt==5, o==10.
REQ-031 iter_limit=4 with disable_req on the 4th RUN cycle -> aborted==1, iter_cnt==3. Separately, start during RUN -> ignored.
REQ-032 rst_n low during RUN at iter_cnt==2 -> immediate IDLE, o==1, no done pulse after release.
REQ-033 With LOOP_SEQUENCER_WATCHDOG_EN and WDOG_CYCLES=8, iter_limit=0, no disable_req -> done after 8 RUN cycles with timeout==1, aborted==1, iter_cnt==7.

Source files
------------

// File: rtl/loop_sequencer.sv
// Purpose: iteration sequencer. It runs a loop body that writes body_val to o, for
//          iter_limit iterations or forever when iter_limit is 0, and can be aborted.
// Latency: start accepted in IDLE -> first o write on the next edge -> done pulse one
//          cycle after the exit edge.
// Backpressure: none. start is only sampled in IDLE, and disable_req only acts in RUN.
// Ports: clk/rst_n (async active-low); start, disable_req, iter_limit, body_val in;
//        o, busy, done, aborted, iter_cnt, timeout out.
// Option: LOOP_SEQUENCER_WATCHDOG_EN adds a RUN-cycle watchdog of WDOG_CYCLES cycles.
module loop_sequencer #(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              disable_req,
  input  logic [CNT_W-1:0]  iter_limit,
  input  logic [DATA_W-1:0] body_val,
  output logic [DATA_W-1:0] o,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  iter_cnt,
  output logic              timeout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    limit_q, limit_nxt;
  logic [DATA_W-1:0]   body_q, body_nxt;
  logic [DATA_W-1:0]   o_nxt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                aborted_nxt;
  logic                timeout_q, timeout_nxt;
  logic [CNT_W-1:0]    cnt_inc;
  logic                last_iter;
  logic                wd_expire;

  // The counter saturates at all-ones so that forever loops never wrap.
  assign cnt_inc   = (iter_cnt == {CNT_W{1'b1}}) ? iter_cnt : iter_cnt + CNT_W'(1);
  assign last_iter = (limit_q != '0) && (cnt_inc == limit_q);

`ifdef LOOP_SEQUENCER_WATCHDOG_EN
  localparam int WD_W = (WDOG_CYCLES < 2) ? 1 : $clog2(WDOG_CYCLES);
  logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;

  // wd_cnt holds the number of RUN cycles that have already elapsed. The edge that
  // closes RUN cycle number WDOG_CYCLES is therefore the expiry edge.
  assign wd_expire = (wd_cnt == WD_W'(WDOG_CYCLES - 1));

  always_comb begin
    wd_cnt_nxt = wd_cnt;
    if (state == IDLE && start) wd_cnt_nxt = '0;
    else if (state == RUN)      wd_cnt_nxt = wd_cnt + WD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_cnt <= '0;
    else        wd_cnt <= wd_cnt_nxt;
  end

  assign timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    limit_nxt   = limit_q;
    body_nxt    = body_q;
    o_nxt       = o;
    cnt_nxt     = iter_cnt;
    aborted_nxt = aborted;
    timeout_nxt = timeout_q;
    case (state)
      IDLE: begin
        // A disable_req that arrives together with start is ignored.
        if (start) begin
          limit_nxt   = iter_limit;
          body_nxt    = body_val;
          cnt_nxt     = '0;
          aborted_nxt = 1'b0;
          timeout_nxt = 1'b0;
          state_nxt   = RUN;
        end
      end
      RUN: begin
        if (disable_req) begin
          // Abort without running the body, even on what would be the final iteration.
          aborted_nxt = 1'b0 | 1'b1;
          state_nxt   = DONE;
        end else if (wd_expire && !last_iter) begin
          aborted_nxt = 1'b1;
          timeout_nxt = 1'b1;
          state_nxt   = DONE;
        end else begin
          o_nxt   = body_q;
          cnt_nxt = cnt_inc;
          if (last_iter) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      limit_q   <= '0;
      body_q    <= '0;
      o         <= DATA_W'(1);
      iter_cnt  <= '0;
      aborted   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      limit_q   <= limit_nxt;
      body_q    <= body_nxt;
      o         <= o_nxt;
      iter_cnt  <= cnt_nxt;
      aborted   <= aborted_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_loop_sequencer.sv
// Testbench for loop_sequencer. It uses directed loops plus randomized loops, checked
// against a loop-outcome model that works out each expected exit from the loop rules.
module tb_loop_sequencer;

  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = 15;
  localparam int INF  = 1000;
`ifdef LOOP_SEQUENCER_WATCHDOG_EN
  localparam int WD = 8;
`else
  localparam int WD = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          disable_req;
  logic [CW-1:0] iter_limit;
  logic [DW-1:0] body_val;
  logic [DW-1:0] o;
  logic          busy, done, aborted, timeout;
  logic [CW-1:0] iter_cnt;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] prev_o;

  loop_sequencer #(.DATA_W(DW), .CNT_W(CW), .WDOG_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .disable_req(disable_req),
    .iter_limit(iter_limit), .body_val(body_val), .o(o), .busy(busy), .done(done),
    .aborted(aborted), .iter_cnt(iter_cnt), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Runs one loop with limit n and body value b. disable_req is raised during RUN cycle
  // k (1-based), and k = 0 means no disable.
  task automatic run_loop(input int n, input logic [DW-1:0] b, input int k, input string nm);
    int e_comp, e_dis, e_wd, ex, iters;
    logic exp_ab, exp_to;
    e_comp = (n > 0) ? n : INF;
    e_dis  = (k > 0) ? k : INF;
    e_wd   = (WD > 0) ? WD : INF;
    ex     = imin(e_comp, imin(e_dis, e_wd));
    if (e_dis == ex)       begin exp_ab = 1; exp_to = 0; iters = k - 1;  end
    else if (e_comp == ex) begin exp_ab = 0; exp_to = 0; iters = n;      end
    else                   begin exp_ab = 1; exp_to = 1; iters = WD - 1; end

    // An idle cycle with a stray disable_req must leave no trace.
    start = 0; disable_req = 1'($urandom); tick();
    check({nm, ":idle_busy"}, DW'(busy), 0);
    check({nm, ":idle_done"}, DW'(done), 0);

    start = 1; iter_limit = CW'(n); body_val = b; disable_req = 1'($urandom);
    tick();
    check({nm, ":run0_busy"}, DW'(busy), 1);
    check({nm, ":run0_cnt"}, DW'(iter_cnt), 0);
    check({nm, ":run0_ab"}, DW'(aborted), 0);
    check({nm, ":run0_o"}, o, prev_o);
    // Change the latched inputs to show that they are sampled only at start.
    iter_limit = CW'($urandom); body_val = $urandom;
    disable_req = (k == 1);
    start = 1'($urandom);

    for (int c = 1; c <= ex; c++) begin
      tick();
      if (c == ex) begin
        check({nm, ":done"}, DW'(done), 1);
        check({nm, ":done_busy"}, DW'(busy), 0);
        check({nm, ":done_cnt"}, DW'(iter_cnt), DW'(imin(iters, CMAX)));
        check({nm, ":done_ab"}, DW'(aborted), DW'(exp_ab));
        check({nm, ":done_to"}, DW'(timeout), DW'(exp_to));
        if (iters > 0) prev_o = b;
        check({nm, ":done_o"}, o, prev_o);
      end else begin
        check({nm, ":run_busy"}, DW'(busy), 1);
        check({nm, ":run_done"}, DW'(done), 0);
        check({nm, ":run_cnt"}, DW'(iter_cnt), DW'(imin(c, CMAX)));
        check({nm, ":run_o"}, o, b);
        disable_req = (c + 1 == k);
        start = 1'($urandom);
      end
    end

    // A start raised in DONE is ignored, and the results hold into IDLE.
    start = 1; disable_req = 0; tick();
    check({nm, ":post_busy"}, DW'(busy), 0);
    check({nm, ":post_done"}, DW'(done), 0);
    check({nm, ":post_cnt"}, DW'(iter_cnt), DW'(imin(iters, CMAX)));
    check({nm, ":post_ab"}, DW'(aborted), DW'(exp_ab));
    check({nm, ":post_o"}, o, prev_o);
    start = 0;
  endtask

  initial begin
    rst_n = 0; start = 0; disable_req = 0; iter_limit = '0; body_val = '0;
    prev_o = DW'(1);
    #12;
    check("rst_o", o, 1);
    check("rst_cnt", DW'(iter_cnt), 0);
    check("rst_busy", DW'(busy), 0);
    check("rst_done", DW'(done), 0);
    check("rst_to", DW'(timeout), 0);
    @(negedge clk); rst_n = 1;
    tick();

    run_loop(3, 10, 0, "lim3");
    run_loop(0, 10, 6, "forever_dis");
    run_loop(4, 32'h55, 4, "dis_last");
    run_loop(1, 32'hABCD, 0, "lim1");
    run_loop(2, 32'h77, 1, "dis_first");
    if (WD == 0) run_loop(0, 32'h99, 20, "saturate");
`ifdef LOOP_SEQUENCER_WATCHDOG_EN
    run_loop(0, 10, 0, "wdog");
    run_loop(8, 32'h42, 0, "wdog_vs_comp");
    run_loop(0, 32'h43, 8, "wdog_vs_dis");
`endif

    // Reset in the middle of a loop.
    start = 1; iter_limit = CW'(5); body_val = 32'h1234; tick();
    start = 0; tick(); tick();
    check("mid_cnt", DW'(iter_cnt), 2);
    #2 rst_n = 0; #1;
    check("arst_o", o, 1);
    check("arst_cnt", DW'(iter_cnt), 0);
    check("arst_busy", DW'(busy), 0);
    check("arst_done", DW'(done), 0);
    @(negedge clk); rst_n = 1;
    prev_o = DW'(1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_done", DW'(done), 0);
      check("post_rst_busy", DW'(busy), 0);
    end

    for (int t = 0; t < 25; t++) begin
      int n, k;
      n = $urandom_range(0, CMAX);
      k = $urandom_range(0, 20);
      if (n == 0 && k == 0 && WD == 0) k = $urandom_range(1, 20);
      run_loop(n, $urandom, k, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
